// File: rtl/mdu_iq.sv
// Compacting issue queue for the MDU pipeline: holds dispatched mul/div ops until
// their operands are ready or forwardable. Optional counters via MDU_IQ_PERF_COUNTERS_EN.
module mdu_iq #(
    parameter int MDU_IQ_ENTRIES     = 8,
    parameter int PR_COUNT           = 128,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int ROB_ENTRIES        = 64,
    parameter int LOG_PR_COUNT       = $clog2(PR_COUNT),
    parameter int LOG_PRF_BANK_COUNT = $clog2(PRF_BANK_COUNT),
    parameter int LOG_ROB_ENTRIES    = $clog2(ROB_ENTRIES)
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          dispatch_valid,
    input  logic [2:0]                    dispatch_op,
    input  logic [LOG_PR_COUNT-1:0]       dispatch_A_PR,
    input  logic                          dispatch_A_ready,
    input  logic                          dispatch_A_is_zero,
    input  logic [LOG_PR_COUNT-1:0]       dispatch_B_PR,
    input  logic                          dispatch_B_ready,
    input  logic                          dispatch_B_is_zero,
    input  logic [LOG_PR_COUNT-1:0]       dispatch_dest_PR,
    input  logic [LOG_ROB_ENTRIES-1:0]    dispatch_ROB_index,
    output logic                          dispatch_ack,
    input  logic [PRF_BANK_COUNT-1:0]     WB_bus_valid_by_bank,
    input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0] WB_bus_upper_PR_by_bank,
    output logic                          issue_valid,
    output logic [2:0]                    issue_op,
    output logic                          issue_A_forward,
    output logic                          issue_A_is_zero,
    output logic [LOG_PR_COUNT-1:0]       issue_A_PR,
    output logic                          issue_B_forward,
    output logic                          issue_B_is_zero,
    output logic [LOG_PR_COUNT-1:0]       issue_B_PR,
    output logic [LOG_PR_COUNT-1:0]       issue_dest_PR,
    output logic [LOG_ROB_ENTRIES-1:0]    issue_ROB_index,
    input  logic                          issue_ready,
    output logic                          PRF_req_A_valid,
    output logic [LOG_PR_COUNT-1:0]       PRF_req_A_PR,
    output logic                          PRF_req_B_valid,
    output logic [LOG_PR_COUNT-1:0]       PRF_req_B_PR
`ifdef MDU_IQ_PERF_COUNTERS_EN
    ,
    output logic [31:0]                   perf_issue_count,
    output logic [31:0]                   perf_full_stall_count
`endif
);
    localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
    localparam int IDX_W   = $clog2(MDU_IQ_ENTRIES);
    localparam int CNT_W   = $clog2(MDU_IQ_ENTRIES + 1);

    typedef struct packed {
        logic                       valid;
        logic [2:0]                 op;
        logic [LOG_PR_COUNT-1:0]    a_pr;
        logic                       a_ready;
        logic                       a_is_zero;
        logic [LOG_PR_COUNT-1:0]    b_pr;
        logic                       b_ready;
        logic                       b_is_zero;
        logic [LOG_PR_COUNT-1:0]    dest_pr;
        logic [LOG_ROB_ENTRIES-1:0] rob_index;
    } entry_t;

    function automatic logic wb_match(
        input logic [LOG_PR_COUNT-1:0]                  pr,
        input logic [PRF_BANK_COUNT-1:0]                wb_valid,
        input logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0]   wb_upper
    );
        logic [LOG_PRF_BANK_COUNT-1:0] bank;
        bank = pr[LOG_PRF_BANK_COUNT-1:0];
        return wb_valid[bank] && (wb_upper[bank] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
    endfunction

    entry_t q_reg   [MDU_IQ_ENTRIES];
    entry_t q_next  [MDU_IQ_ENTRIES];
    entry_t woken   [MDU_IQ_ENTRIES];
    entry_t sel_entry;
    entry_t new_entry;

    logic [MDU_IQ_ENTRIES-1:0] a_match;
    logic [MDU_IQ_ENTRIES-1:0] b_match;
    logic [MDU_IQ_ENTRIES-1:0] cand;
    logic [IDX_W-1:0]          sel_idx;
    logic                      found;
    logic                      sel_a_match;
    logic                      sel_b_match;
    logic                      full;
    logic [CNT_W-1:0]          occ;
    logic [CNT_W-1:0]          wr_idx;
    logic                      disp_a_match;
    logic                      disp_b_match;

    generate
        for (genvar gi = 0; gi < MDU_IQ_ENTRIES; gi++) begin : g_entry
            assign a_match[gi] = wb_match(q_reg[gi].a_pr, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
            assign b_match[gi] = wb_match(q_reg[gi].b_pr, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
            assign cand[gi]    = q_reg[gi].valid
                               & (q_reg[gi].a_ready | q_reg[gi].a_is_zero | a_match[gi])
                               & (q_reg[gi].b_ready | q_reg[gi].b_is_zero | b_match[gi]);
        end
    endgenerate

    // Scan from the top so the lowest-index (oldest) candidate wins.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        for (int i = MDU_IQ_ENTRIES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_entry   = found ? q_reg[sel_idx] : '0;
        sel_a_match = found & a_match[sel_idx];
        sel_b_match = found & b_match[sel_idx];
    end

    assign issue_valid     = issue_ready & found;
    assign issue_op        = sel_entry.op;
    assign issue_A_PR      = sel_entry.a_pr;
    assign issue_A_is_zero = sel_entry.a_is_zero;
    assign issue_A_forward = sel_a_match & ~sel_entry.a_ready & ~sel_entry.a_is_zero;
    assign issue_B_PR      = sel_entry.b_pr;
    assign issue_B_is_zero = sel_entry.b_is_zero;
    assign issue_B_forward = sel_b_match & ~sel_entry.b_ready & ~sel_entry.b_is_zero;
    assign issue_dest_PR   = sel_entry.dest_pr;
    assign issue_ROB_index = sel_entry.rob_index;

    assign PRF_req_A_valid = issue_valid & sel_entry.a_ready & ~sel_entry.a_is_zero;
    assign PRF_req_A_PR    = issue_A_PR;
    assign PRF_req_B_valid = issue_valid & sel_entry.b_ready & ~sel_entry.b_is_zero;
    assign PRF_req_B_PR    = issue_B_PR;

    always_comb begin
        occ = '0;
        for (int i = 0; i < MDU_IQ_ENTRIES; i++) begin
            occ = occ + CNT_W'(q_reg[i].valid);
        end
    end

    assign full         = q_reg[MDU_IQ_ENTRIES-1].valid;
    assign dispatch_ack = dispatch_valid & (~full | issue_valid);
    assign wr_idx       = occ - CNT_W'(issue_valid);

    assign disp_a_match = wb_match(dispatch_A_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);
    assign disp_b_match = wb_match(dispatch_B_PR, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank);

    always_comb begin
        new_entry           = '0;
        new_entry.valid     = 1'b1;
        new_entry.op        = dispatch_op;
        new_entry.a_pr      = dispatch_A_PR;
        new_entry.a_ready   = dispatch_A_ready | disp_a_match;
        new_entry.a_is_zero = dispatch_A_is_zero;
        new_entry.b_pr      = dispatch_B_PR;
        new_entry.b_ready   = dispatch_B_ready | disp_b_match;
        new_entry.b_is_zero = dispatch_B_is_zero;
        new_entry.dest_pr   = dispatch_dest_PR;
        new_entry.rob_index = dispatch_ROB_index;
    end

    always_comb begin
        for (int i = 0; i < MDU_IQ_ENTRIES; i++) begin
            woken[i]         = q_reg[i];
            woken[i].a_ready = q_reg[i].a_ready | a_match[i];
            woken[i].b_ready = q_reg[i].b_ready | b_match[i];
        end
    end

    // Remove the issued slot, shift younger entries down, then append the dispatch.
    always_comb begin
        for (int i = 0; i < MDU_IQ_ENTRIES; i++) begin
            q_next[i] = '0;
            if (issue_valid && (i >= int'(sel_idx))) begin
                if (i < MDU_IQ_ENTRIES - 1) begin
                    q_next[i] = woken[i+1];
                end
            end else begin
                q_next[i] = woken[i];
            end
            if (dispatch_ack && (CNT_W'(i) == wr_idx)) begin
                q_next[i] = new_entry;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < MDU_IQ_ENTRIES; i++) begin
                q_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MDU_IQ_ENTRIES; i++) begin
                q_reg[i] <= q_next[i];
            end
        end
    end

`ifdef MDU_IQ_PERF_COUNTERS_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_issue_count      <= '0;
            perf_full_stall_count <= '0;
        end else begin
            if (issue_valid) begin
                perf_issue_count <= perf_issue_count + 32'd1;
            end
            if (dispatch_valid && !dispatch_ack) begin
                perf_full_stall_count <= perf_full_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mdu_iq.sv
// Directed self-checking bench for mdu_iq (4 PRF banks, 7-bit PR, 8-entry queue).
module tb_mdu_iq;
    localparam int LPR  = 7;
    localparam int NB   = 4;
    localparam int LROB = 6;
    localparam int UW   = 5;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            dispatch_valid;
    logic [2:0]      dispatch_op;
    logic [LPR-1:0]  dispatch_A_PR;
    logic            dispatch_A_ready;
    logic            dispatch_A_is_zero;
    logic [LPR-1:0]  dispatch_B_PR;
    logic            dispatch_B_ready;
    logic            dispatch_B_is_zero;
    logic [LPR-1:0]  dispatch_dest_PR;
    logic [LROB-1:0] dispatch_ROB_index;
    logic            dispatch_ack;
    logic [NB-1:0]   wb_valid;
    logic [NB-1:0][UW-1:0] wb_upper;
    logic            issue_valid;
    logic [2:0]      issue_op;
    logic            issue_A_forward;
    logic            issue_A_is_zero;
    logic [LPR-1:0]  issue_A_PR;
    logic            issue_B_forward;
    logic            issue_B_is_zero;
    logic [LPR-1:0]  issue_B_PR;
    logic [LPR-1:0]  issue_dest_PR;
    logic [LROB-1:0] issue_ROB_index;
    logic            issue_ready;
    logic            PRF_req_A_valid;
    logic [LPR-1:0]  PRF_req_A_PR;
    logic            PRF_req_B_valid;
    logic [LPR-1:0]  PRF_req_B_PR;
`ifdef MDU_IQ_PERF_COUNTERS_EN
    logic [31:0]     perf_issue_count;
    logic [31:0]     perf_full_stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    mdu_iq #(.MDU_IQ_ENTRIES(8), .PR_COUNT(128), .PRF_BANK_COUNT(4), .ROB_ENTRIES(64)) dut (
        .CLK(CLK), .nRST(nRST),
        .dispatch_valid(dispatch_valid), .dispatch_op(dispatch_op),
        .dispatch_A_PR(dispatch_A_PR), .dispatch_A_ready(dispatch_A_ready),
        .dispatch_A_is_zero(dispatch_A_is_zero),
        .dispatch_B_PR(dispatch_B_PR), .dispatch_B_ready(dispatch_B_ready),
        .dispatch_B_is_zero(dispatch_B_is_zero),
        .dispatch_dest_PR(dispatch_dest_PR), .dispatch_ROB_index(dispatch_ROB_index),
        .dispatch_ack(dispatch_ack),
        .WB_bus_valid_by_bank(wb_valid), .WB_bus_upper_PR_by_bank(wb_upper),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_A_forward(issue_A_forward), .issue_A_is_zero(issue_A_is_zero),
        .issue_A_PR(issue_A_PR),
        .issue_B_forward(issue_B_forward), .issue_B_is_zero(issue_B_is_zero),
        .issue_B_PR(issue_B_PR),
        .issue_dest_PR(issue_dest_PR), .issue_ROB_index(issue_ROB_index),
        .issue_ready(issue_ready),
        .PRF_req_A_valid(PRF_req_A_valid), .PRF_req_A_PR(PRF_req_A_PR),
        .PRF_req_B_valid(PRF_req_B_valid), .PRF_req_B_PR(PRF_req_B_PR)
`ifdef MDU_IQ_PERF_COUNTERS_EN
        , .perf_issue_count(perf_issue_count), .perf_full_stall_count(perf_full_stall_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_dispatch(input logic [2:0] op, input logic [LPR-1:0] a, input logic ar,
                                input logic az, input logic [LPR-1:0] b, input logic br,
                                input logic bz, input logic [LPR-1:0] dest, input logic [LROB-1:0] rob);
        dispatch_valid     = 1'b1;
        dispatch_op        = op;
        dispatch_A_PR      = a;
        dispatch_A_ready   = ar;
        dispatch_A_is_zero = az;
        dispatch_B_PR      = b;
        dispatch_B_ready   = br;
        dispatch_B_is_zero = bz;
        dispatch_dest_PR   = dest;
        dispatch_ROB_index = rob;
    endtask

    // Drive a writeback of one PR onto its bank's slot of the bus.
    task automatic wake_pr(input logic [LPR-1:0] pr);
        wb_valid[pr[1:0]] = 1'b1;
        wb_upper[pr[1:0]] = pr[6:2];
    endtask

    task automatic wb_clear();
        wb_valid = '0;
        wb_upper = '0;
    endtask

    int wl [8] = '{0, 1, 2, 4, 5, 6, 7, 8};

    initial begin
        dispatch_valid = 1'b0;
        set_dispatch(3'd0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        dispatch_valid = 1'b1;
        wb_clear();
        issue_ready = 1'b1;

        // Reset state
        #3;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_prf_a_valid", PRF_req_A_valid, 0);
        check("rst_prf_b_valid", PRF_req_B_valid, 0);
        check("rst_ack_follows", dispatch_ack, 1);
        dispatch_valid = 1'b0;
        tick();
        tick();
        nRST = 1'b1;

        // MUL with both operands already written back
        set_dispatch(3'b000, 7'd5, 1'b1, 1'b0, 7'd9, 1'b1, 1'b0, 7'd20, 6'd1);
        settle();
        check("s1_ack", dispatch_ack, 1);
        check("s1_no_same_cycle_issue", issue_valid, 0);
        tick();
        dispatch_valid = 1'b0;
        settle();
        check("s1_issue_valid", issue_valid, 1);
        check("s1_issue_op", issue_op, 3'b000);
        check("s1_prf_a_valid", PRF_req_A_valid, 1);
        check("s1_prf_a_pr", PRF_req_A_PR, 5);
        check("s1_prf_b_valid", PRF_req_B_valid, 1);
        check("s1_prf_b_pr", PRF_req_B_PR, 9);
        check("s1_a_fwd", issue_A_forward, 0);
        check("s1_b_fwd", issue_B_forward, 0);
        check("s1_dest", issue_dest_PR, 20);
        tick();
        settle();
        check("s1_empty_after", issue_valid, 0);
        tick();

        // DIV with A waiting on WB and B = x0
        set_dispatch(3'b100, 7'h25, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 7'd30, 6'd2);
        settle();
        check("s2_ack", dispatch_ack, 1);
        tick();
        dispatch_valid = 1'b0;
        settle();
        check("s2_wait", issue_valid, 0);
        tick();
        wake_pr(7'h25);
        settle();
        check("s2_issue_valid", issue_valid, 1);
        check("s2_issue_op", issue_op, 3'b100);
        check("s2_a_fwd", issue_A_forward, 1);
        check("s2_b_zero", issue_B_is_zero, 1);
        check("s2_b_fwd", issue_B_forward, 0);
        check("s2_prf_a_valid", PRF_req_A_valid, 0);
        check("s2_prf_b_valid", PRF_req_B_valid, 0);
        check("s2_rob", issue_ROB_index, 2);
        tick();
        wb_clear();
        settle();
        check("s2_empty_after", issue_valid, 0);
        tick();

        // Fill all 8 slots with unready ops (A = 16+i, B = 42+i)
        for (int i = 0; i < 8; i++) begin
            set_dispatch(3'b001, 7'(16 + i), 1'b0, 1'b0, 7'(42 + i), 1'b0, 1'b0, 7'(60 + i), 6'(i));
            settle();
            check($sformatf("s3_fill_ack%0d", i), dispatch_ack, 1);
            tick();
        end
        set_dispatch(3'b001, 7'd24, 1'b0, 1'b0, 7'd50, 1'b0, 1'b0, 7'd68, 6'd8);
        settle();
        check("s3_full_ack", dispatch_ack, 0);
        check("s3_full_no_issue", issue_valid, 0);
        tick();
        wake_pr(7'd19);
        wake_pr(7'd45);
        settle();
        check("s3_wake3_valid", issue_valid, 1);
        check("s3_wake3_rob", issue_ROB_index, 3);
        check("s3_wake3_a_fwd", issue_A_forward, 1);
        check("s3_wake3_b_fwd", issue_B_forward, 1);
        check("s3_full_issue_ack", dispatch_ack, 1);
        tick();
        dispatch_valid = 1'b0;
        issue_ready = 1'b0;
        // Wake every remaining entry while the pipe is stalled
        for (int k = 0; k < 8; k++) begin
            wb_clear();
            wake_pr(7'(16 + wl[k]));
            wake_pr(7'(42 + wl[k]));
            settle();
            check($sformatf("s3_stall_no_issue%0d", k), issue_valid, 0);
            tick();
        end
        wb_clear();
        issue_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            settle();
            check($sformatf("s3_order_valid%0d", k), issue_valid, 1);
            check($sformatf("s3_order_rob%0d", k), issue_ROB_index, wl[k]);
            tick();
        end
        settle();
        check("s3_drained", issue_valid, 0);
        tick();

        // Two ready entries around an unready one, pipe stalled 3 cycles
        issue_ready = 1'b0;
        set_dispatch(3'b010, 7'd1, 1'b1, 1'b0, 7'd2, 1'b1, 1'b0, 7'd40, 6'd10);
        tick();
        set_dispatch(3'b010, 7'd70, 1'b0, 1'b0, 7'd71, 1'b0, 1'b0, 7'd41, 6'd11);
        tick();
        set_dispatch(3'b011, 7'd3, 1'b1, 1'b0, 7'd0, 1'b0, 1'b1, 7'd42, 6'd12);
        tick();
        dispatch_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("s4_hold%0d", c), issue_valid, 0);
            tick();
        end
        issue_ready = 1'b1;
        settle();
        check("s4_first_valid", issue_valid, 1);
        check("s4_first_rob", issue_ROB_index, 10);
        tick();
        settle();
        check("s4_second_rob", issue_ROB_index, 12);
        check("s4_second_prf_a_pr", PRF_req_A_PR, 3);
        check("s4_second_prf_b_valid", PRF_req_B_valid, 0);
        tick();
        settle();
        check("s4_unready_left", issue_valid, 0);
        tick();

        // WB hit on A in the dispatch cycle is captured as ready
        set_dispatch(3'b000, 7'h25, 1'b0, 1'b0, 7'd6, 1'b1, 1'b0, 7'd43, 6'd13);
        wake_pr(7'h25);
        settle();
        check("s5_ack", dispatch_ack, 1);
        check("s5_no_same_cycle_issue", issue_valid, 0);
        tick();
        dispatch_valid = 1'b0;
        wb_clear();
        settle();
        check("s5_issue_valid", issue_valid, 1);
        check("s5_rob", issue_ROB_index, 13);
        check("s5_a_fwd", issue_A_forward, 0);
        check("s5_prf_a_valid", PRF_req_A_valid, 1);
        check("s5_prf_a_pr", PRF_req_A_PR, 7'h25);
        tick();

        // Build up 5 entries (rob 11 is still queued), then reset mid-stream
        for (int i = 0; i < 3; i++) begin
            set_dispatch(3'b001, 7'(80 + 2 * i), 1'b0, 1'b0, 7'(81 + 2 * i), 1'b0, 1'b0, 7'd44, 6'(14 + i));
            tick();
        end
        set_dispatch(3'b001, 7'd1, 1'b1, 1'b0, 7'd2, 1'b1, 1'b0, 7'd45, 6'd17);
        tick();
        dispatch_valid = 1'b0;
        settle();
        check("s6_pre_rst_valid", issue_valid, 1);
        check("s6_pre_rst_rob", issue_ROB_index, 17);
        #1;
        nRST = 1'b0;
        #1;
        check("s6_rst_issue_valid", issue_valid, 0);
        check("s6_rst_prf_a_valid", PRF_req_A_valid, 0);
        dispatch_valid = 1'b1;
        #1;
        check("s6_rst_ack_follows", dispatch_ack, 1);
        dispatch_valid = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_dispatch(3'b101, 7'(90 + i), 1'b0, 1'b0, 7'(100 + i), 1'b0, 1'b0, 7'd46, 6'(20 + i));
            settle();
            check($sformatf("s6_refill_ack%0d", i), dispatch_ack, 1);
            tick();
        end
        set_dispatch(3'b101, 7'd98, 1'b0, 1'b0, 7'd108, 1'b0, 1'b0, 7'd46, 6'd28);
        settle();
        check("s6_refill_full_ack", dispatch_ack, 0);
        check("s6_refill_no_issue", issue_valid, 0);
        dispatch_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_iq.md
Name: mdu_iq

Overview:
- Issue queue feeding the MDU pipeline.
- Accepts one dispatched mul/div op per cycle from the dispatch stage and holds it until its operands are ready or forwardable.
- Tracks operand readiness by snooping the per-bank writeback bus.
- Issues the oldest ready op to the MDU pipeline under its issue_ready backpressure, and sends matching PRF read requests for operands that were already written back.

Parameters:
- MDU_IQ_ENTRIES, 8, queue depth (>=2).
- PR_COUNT, PRF_BANK_COUNT, ROB_ENTRIES and their LOG_ forms come from core_types_pkg.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- dispatch_valid  in  1  op offered this cycle
- dispatch_op  in  3  MDU op (bit2 = div, bit1:0 = subop)
- dispatch_A_PR  in  LOG_PR_COUNT  source A PR
- dispatch_A_ready  in  1  A already written back
- dispatch_A_is_zero  in  1  A is x0
- dispatch_B_PR  in  LOG_PR_COUNT  source B PR
- dispatch_B_ready  in  1  B already written back
- dispatch_B_is_zero  in  1  B is x0
- dispatch_dest_PR  in  LOG_PR_COUNT  destination PR
- dispatch_ROB_index  in  LOG_ROB_ENTRIES  ROB index
- dispatch_ack  out  1  op accepted this cycle
- WB_bus_valid_by_bank  in  PRF_BANK_COUNT  writeback valid per bank
- WB_bus_upper_PR_by_bank  in  PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  written PR upper bits per bank
- issue_valid  out  1  op issued
- issue_op  out  3  op
- issue_A_forward  out  1  A taken from forward path
- issue_A_is_zero  out  1
- issue_A_PR  out  LOG_PR_COUNT
- issue_B_forward  out  1  B taken from forward path
- issue_B_is_zero  out  1
- issue_B_PR  out  LOG_PR_COUNT
- issue_dest_PR  out  LOG_PR_COUNT
- issue_ROB_index  out  LOG_ROB_ENTRIES
- issue_ready  in  1  MDU pipeline can accept
- PRF_req_A_valid  out  1  read request for A
- PRF_req_A_PR  out  LOG_PR_COUNT
- PRF_req_B_valid  out  1  read request for B
- PRF_req_B_PR  out  LOG_PR_COUNT

Behaviour:
- Storage
  - Compacting queue: entry 0 is the oldest.
  - Each entry holds valid, op, A/B PR, A/B ready, A/B is_zero, dest_PR, ROB_index.
- Operand wakeup
  - An operand matches when WB_bus_valid_by_bank[PR[LOG_PRF_BANK_COUNT-1:0]] is high and the bank's upper bits equal PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT].
  - A matching operand sets its ready bit at the clock edge.
- Operand availability
  - An operand is available if it is ready, or is_zero, or matches this cycle.
  - A candidate entry has valid set and both operands available.
- Issue selection (combinational)
  - Select the lowest-index candidate.
  - issue_valid = issue_ready & candidate exists.
  - All issue_* fields come from the selected entry.
  - issue_X_forward = operand matches the WB bus this cycle & ~ready & ~is_zero.
  - issue_X_is_zero passes through.
- PRF requests
  - PRF_req_X_valid = issue_valid & X ready & ~X is_zero.
  - PRF_req_X_PR = issue_X_PR.
  - The PRF replies two cycles later (ack in the MDU OC stage).
- Issue removal and compaction
  - The issued entry is removed at the edge; all younger entries shift down one slot.
  - Wakeup applies to shifted entries in the same edge.
- Dispatch
  - dispatch_ack = dispatch_valid & (not full | issue_valid).
  - An accepted op is written at the first free slot after compaction.
  - Its ready bits = dispatch_X_ready | matches this cycle.
  - A dispatched op is never issued in its dispatch cycle; earliest issue is the next cycle.
- Boundaries
  - Full with no issue: dispatch_ack=0.
  - Full with issue: accept; the new op lands at index MDU_IQ_ENTRIES-1.
  - Empty: issue_valid=0.
  - issue_ready=0: no removal; wakeup continues.
  - An operand that is both is_zero and matching is treated as is_zero, with forward=0.
- Reset (async)
  - All valid bits cleared.
  - Outputs then evaluate to 0: issue_valid=0, PRF_req_*_valid=0, dispatch_ack follows dispatch_valid.
  - Reset mid-operation discards all entries.

Optional Feature:
- Macro: MDU_IQ_PERF_COUNTERS_EN.
- When defined:
  - Adds outputs perf_issue_count[31:0] (increments per issue_valid) and perf_full_stall_count[31:0] (increments when dispatch_valid & ~dispatch_ack).
  - Both reset to 0 and wrap at 2^32.
- When undefined: no counter ports or logic.

Test Plan (PRF_BANK_COUNT=4, LOG_PR_COUNT=7):
- Dispatch MUL with A=PR 5 ready, B=PR 9 ready, issue_ready=1 -> next cycle issue_valid=1, PRF_req_A_PR=5, PRF_req_B_PR=9, both forward=0, queue empty after.
- Dispatch DIV with A=PR 0x25 not ready, B is_zero. Then WB bank1 upper=0x09 -> issue_valid that cycle with issue_A_forward=1, PRF_req_A_valid=0, PRF_req_B_valid=0.
- Fill 8 entries, none ready -> 9th dispatch_ack=0.
  - Then wake entry 3 -> it issues.
  - Same-cycle dispatch acked into index 7; order of the remaining entries preserved.
- Entries 0 and 2 both ready, issue_ready=0 for 3 cycles -> issue_valid=0, no removal.
  - issue_ready=1 -> entry 0 (oldest) issues first, then entry 2.
- WB match for a dispatching op's A in the same cycle as dispatch -> entry stored ready, issues next cycle with forward=0 and PRF_req_A_valid=1.
- Assert nRST low mid-stream with 5 entries -> issue_valid=0 immediately. After release, the queue accepts 8 new ops.
